mod_n_contador: RTL and testbench

Parametrised modulo-N counter, successor to the fixed mod-6 enable counter used for timekeeping digits.
- Adds up/down counting, synchronous parallel load, wrap or saturate mode, and a registered carry/borrow pulse.
- Instances chain via carry_o -> cnt of the next digit to build seconds/minutes/hours chains without per-modulus custom logic.

---
 rtl/mod_n_contador_if.sv | 24 ++
 rtl/mod_n_contador.sv | 77 +++++++
 tb/tb_mod_n_contador.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_contador_if.sv
// Count-control and status bundle for one mod_n_contador digit.
// master drives the controls; slave is the counter itself.
interface mod_n_contador_if #(
  parameter int unsigned WIDTH = 3
);
  logic             cnt;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             carry_o;
  logic             load_err;

  modport master (
    output cnt, up_dn, load, load_val,
    input  Q, tc, carry_o, load_err
  );

  modport slave (
    input  cnt, up_dn, load, load_val,
    output Q, tc, carry_o, load_err
  );
endinterface

// File: rtl/mod_n_contador.sv
// Modulo-N up/down digit counter with parallel load, wrap/saturate mode and a
// registered carry/borrow pulse meant to drive the next digit's cnt.
module mod_n_contador #(
  parameter int unsigned MODULO   = 6,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned SATURATE = 0
) (
  input logic                  clk,
  input logic                  clr,
  mod_n_contador_if.slave      bus
);

  if ((MODULO < 2) || (MODULO > 256) || ((1 << WIDTH) < MODULO)) begin : gen_bad_param
    $error("mod_n_contador: MODULO must be 2..256 and fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2^WIDTH still compares correctly.
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULO);
  localparam bit               Sat    = (SATURATE != 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             at_top, at_bot;

  assign at_top = (q_q == MaxVal);
  assign at_bot = (q_q == '0);

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    err_d   = err_q;
    if (bus.load) begin
      // cnt is ignored on every load cycle, legal value or not.
      if ({1'b0, bus.load_val} < ModExt) begin
        q_d = bus.load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.cnt) begin
      if (bus.up_dn) begin
        if (!at_top) begin
          q_d = q_q + 1'b1;
        end else if (!Sat) begin
          q_d     = '0;
          carry_d = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          q_d = q_q - 1'b1;
        end else if (!Sat) begin
          q_d     = MaxVal;
          carry_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q     <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.carry_o  = carry_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.up_dn ? at_top : at_bot;

endmodule

// File: tb/tb_mod_n_contador.sv
// Randomised and directed bench for mod_n_contador: mod-6 wrap, mod-10 saturate,
// and a units(10)->tens(6) cascade, all checked against an arithmetic model.
module tb_mod_n_contador;

  typedef struct {
    int q;
    bit c;
    bit e;
  } st_t;

  logic clk = 1'b0;
  logic clr_a, clr_s, clr_c;
  int   vectors = 0;
  int   miscompares = 0;
  st_t  ma, ms, mu, mt;

  always #5 clk = ~clk;

  mod_n_contador_if #(.WIDTH(3)) ifa ();
  mod_n_contador_if #(.WIDTH(4)) ifs ();
  mod_n_contador_if #(.WIDTH(4)) ifu ();
  mod_n_contador_if #(.WIDTH(3)) ift ();

  assign ift.cnt = ifu.carry_o;

  mod_n_contador #(.MODULO(6), .WIDTH(3), .SATURATE(0)) dut_a (
    .clk (clk), .clr (clr_a), .bus (ifa.slave)
  );
  mod_n_contador #(.MODULO(10), .WIDTH(4), .SATURATE(1)) dut_s (
    .clk (clk), .clr (clr_s), .bus (ifs.slave)
  );
  mod_n_contador #(.MODULO(10), .WIDTH(4), .SATURATE(0)) dut_u (
    .clk (clk), .clr (clr_c), .bus (ifu.slave)
  );
  mod_n_contador #(.MODULO(6), .WIDTH(3), .SATURATE(0)) dut_t (
    .clk (clk), .clr (clr_c), .bus (ift.slave)
  );

  // Reference: next state from plain modular arithmetic.
  function automatic st_t ref_next(st_t s, bit clr, bit ld, int lv, bit cn, bit up,
                                   int m, bit sat);
    st_t n;
    bit  wrap;
    n   = s;
    n.c = 1'b0;
    if (clr) begin
      n.q = 0;
      n.e = 1'b0;
    end else if (ld) begin
      if (lv < m) n.q = lv;
      else        n.e = 1'b1;
    end else if (cn) begin
      wrap = up ? (s.q == m - 1) : (s.q == 0);
      if (wrap && sat) begin
        n.q = s.q;
      end else begin
        n.q = (s.q + (up ? 1 : m - 1)) % m;
        n.c = wrap;
      end
    end
    return n;
  endfunction

  function automatic bit ref_tc(int q, bit up, int m);
    return up ? (q == m - 1) : (q == 0);
  endfunction

  task automatic cyc_a(bit clr, bit ld, int lv, bit cn, bit up);
    clr_a = clr; ifa.load = ld; ifa.load_val = lv[2:0]; ifa.cnt = cn; ifa.up_dn = up;
    @(posedge clk);
    ma = ref_next(ma, clr, ld, lv, cn, up, 6, 1'b0);
    #1;
  endtask

  task automatic cyc_s(bit clr, bit ld, int lv, bit cn, bit up);
    clr_s = clr; ifs.load = ld; ifs.load_val = lv[3:0]; ifs.cnt = cn; ifs.up_dn = up;
    @(posedge clk);
    ms = ref_next(ms, clr, ld, lv, cn, up, 10, 1'b1);
    #1;
  endtask

  task automatic cyc_c(bit clr, bit cn);
    bit carry_prev;
    clr_c = clr; ifu.cnt = cn;
    @(posedge clk);
    carry_prev = mu.c;
    mu = ref_next(mu, clr, 1'b0, 0, cn, 1'b1, 10, 1'b0);
    mt = ref_next(mt, clr, 1'b0, 0, carry_prev, 1'b1, 6, 1'b0);
    #1;
  endtask

  task automatic test_reset;
    cyc_a(1'b1, 1'b1, 3, 1'b1, 1'b1);
    vectors++;
    if (ifa.Q !== 3'd0 || ifa.carry_o !== 1'b0 || ifa.load_err !== 1'b0 || ifa.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got Q=%0d c=%b e=%b tc=%b, want Q=0 c=0 e=0 tc=0",
               ifa.Q, ifa.carry_o, ifa.load_err, ifa.tc);
    end
  endtask

  task automatic test_count_up;
    int pulses = 0;
    for (int i = 0; i < 13; i++) begin
      cyc_a(1'b0, 1'b0, 0, 1'b1, 1'b1);
      pulses += int'(ifa.carry_o);
      vectors++;
      if (ifa.Q !== 3'(ma.q) || ifa.carry_o !== ma.c || ifa.load_err !== ma.e ||
          ifa.tc !== ref_tc(ma.q, 1'b1, 6)) begin
        miscompares++;
        $display("FAIL count_up[%0d]: got Q=%0d c=%b e=%b tc=%b, want Q=%0d c=%b e=%b tc=%b",
                 i, ifa.Q, ifa.carry_o, ifa.load_err, ifa.tc, ma.q, ma.c, ma.e,
                 ref_tc(ma.q, 1'b1, 6));
      end
    end
    vectors++;
    if (pulses !== 2) begin
      miscompares++;
      $display("FAIL count_up_pulses: got %0d, want 2", pulses);
    end
  endtask

  task automatic test_count_down;
    int pulses = 0;
    cyc_a(1'b1, 1'b0, 0, 1'b0, 1'b0);
    vectors++;
    if (ifa.tc !== 1'b1) begin
      miscompares++;
      $display("FAIL down_tc_at_zero: got tc=%b, want 1", ifa.tc);
    end
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b0, 1'b0, 0, 1'b1, 1'b0);
      pulses += int'(ifa.carry_o);
      vectors++;
      if (ifa.Q !== 3'(ma.q) || ifa.carry_o !== ma.c || ifa.tc !== ref_tc(ma.q, 1'b0, 6)) begin
        miscompares++;
        $display("FAIL count_down[%0d]: got Q=%0d c=%b tc=%b, want Q=%0d c=%b tc=%b",
                 i, ifa.Q, ifa.carry_o, ifa.tc, ma.q, ma.c, ref_tc(ma.q, 1'b0, 6));
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL count_down_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_load;
    int lv[4]  = '{4, 7, 0, 0};
    bit ld[4]  = '{1, 1, 0, 0};
    bit cl[4]  = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      cyc_a(cl[i], ld[i], lv[i], 1'b1, 1'b1);
      vectors++;
      if (ifa.Q !== 3'(ma.q) || ifa.carry_o !== ma.c || ifa.load_err !== ma.e) begin
        miscompares++;
        $display("FAIL load[%0d]: got Q=%0d c=%b e=%b, want Q=%0d c=%b e=%b",
                 i, ifa.Q, ifa.carry_o, ifa.load_err, ma.q, ma.c, ma.e);
      end
    end
  endtask

  task automatic test_clr_priority;
    int pulses = 0;
    cyc_a(1'b0, 1'b1, 5, 1'b0, 1'b1);
    cyc_a(1'b1, 1'b1, 3, 1'b1, 1'b1);
    vectors++;
    if (ifa.Q !== 3'(ma.q) || ifa.carry_o !== ma.c) begin
      miscompares++;
      $display("FAIL clr_priority: got Q=%0d c=%b, want Q=%0d c=%b",
               ifa.Q, ifa.carry_o, ma.q, ma.c);
    end
    for (int i = 0; i < 5; i++) begin
      cyc_a(1'b0, 1'b0, 0, 1'b1, 1'b1);
      pulses += int'(ifa.carry_o);
    end
    vectors++;
    if (ifa.Q !== 3'(ma.q) || pulses !== 0) begin
      miscompares++;
      $display("FAIL clr_then_count: got Q=%0d pulses=%0d, want Q=%0d pulses=0",
               ifa.Q, pulses, ma.q);
    end
  endtask

  task automatic test_random_a;
    for (int i = 0; i < 400; i++) begin
      cyc_a(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 3) != 0), 1'($urandom));
      vectors++;
      if (ifa.Q !== 3'(ma.q) || ifa.carry_o !== ma.c || ifa.load_err !== ma.e ||
          ifa.tc !== ref_tc(ma.q, ifa.up_dn, 6)) begin
        miscompares++;
        $display("FAIL random_a[%0d]: got Q=%0d c=%b e=%b tc=%b, want Q=%0d c=%b e=%b tc=%b",
                 i, ifa.Q, ifa.carry_o, ifa.load_err, ifa.tc, ma.q, ma.c, ma.e,
                 ref_tc(ma.q, ifa.up_dn, 6));
      end
    end
  endtask

  task automatic test_saturate;
    bit up;
    cyc_s(1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 224; i++) begin
      // 12 up, 12 down, then random traffic.
      if (i < 24) begin
        up = (i < 12);
        cyc_s(1'b0, 1'b0, 0, 1'b1, up);
      end else begin
        cyc_s(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
              ($urandom_range(0, 3) != 0), 1'($urandom));
      end
      vectors++;
      if (ifs.Q !== 4'(ms.q) || ifs.carry_o !== ms.c || ifs.load_err !== ms.e ||
          ifs.tc !== ref_tc(ms.q, ifs.up_dn, 10)) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got Q=%0d c=%b e=%b tc=%b, want Q=%0d c=%b e=%b tc=%b",
                 i, ifs.Q, ifs.carry_o, ifs.load_err, ifs.tc, ms.q, ms.c, ms.e,
                 ref_tc(ms.q, ifs.up_dn, 10));
      end
    end
  endtask

  task automatic test_cascade;
    int tens_pulses = 0;
    cyc_c(1'b1, 1'b0);
    for (int i = 0; i < 62; i++) begin
      cyc_c(1'b0, 1'b1);
      tens_pulses += int'(ift.carry_o);
      vectors++;
      if (ifu.Q !== 4'(mu.q) || ifu.carry_o !== mu.c || ift.Q !== 3'(mt.q) ||
          ift.carry_o !== mt.c) begin
        miscompares++;
        $display("FAIL cascade[%0d]: got u=%0d uc=%b t=%0d tc=%b, want u=%0d uc=%b t=%0d tc=%b",
                 i, ifu.Q, ifu.carry_o, ift.Q, ift.carry_o, mu.q, mu.c, mt.q, mt.c);
      end
    end
    vectors++;
    if (tens_pulses !== 1 || ift.Q !== 3'd0) begin
      miscompares++;
      $display("FAIL cascade_tens_wrap: got pulses=%0d tens=%0d, want pulses=1 tens=0",
               tens_pulses, ift.Q);
    end
  endtask

  initial begin
    clr_a = 1'b1; clr_s = 1'b1; clr_c = 1'b1;
    ifa.cnt = 1'b0; ifa.up_dn = 1'b1; ifa.load = 1'b0; ifa.load_val = '0;
    ifs.cnt = 1'b0; ifs.up_dn = 1'b1; ifs.load = 1'b0; ifs.load_val = '0;
    ifu.cnt = 1'b0; ifu.up_dn = 1'b1; ifu.load = 1'b0; ifu.load_val = '0;
    ift.up_dn = 1'b1; ift.load = 1'b0; ift.load_val = '0;
    ma = '{q: 0, c: 1'b0, e: 1'b0};
    ms = ma; mu = ma; mt = ma;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_clr_priority();
    test_random_a();
    test_saturate();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
